// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the memory-port arbiter.
// Optional timeout feature is enabled with MEM_ARB_TIMEOUT_EN.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_LS = 2'd2
  } state_t;

  localparam int ADDR_W_DEF  = 32;
  localparam int DATA_W_DEF  = 32;
  localparam int BE_W        = 4;
  localparam int TIMEOUT_DEF = 255;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Counts BUSY cycles since grant; expire is high during the LIMIT-th BUSY cycle.
// Used only when MEM_ARB_TIMEOUT_EN is defined.
module mem_arb_watchdog #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic expire
);

  localparam int CW = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] cnt;

  assign expire = !clear && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (!expire) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store; LS has priority
// with a streak limit against fetch starvation. Timeout abort under MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int MAX_LS_STREAK  = 4,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_err,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  input  logic [BE_W-1:0]   ls_be,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              ls_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [BE_W-1:0]   mem_be,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int SW = $clog2(MAX_LS_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_LS_STREAK);

  if (MAX_LS_STREAK < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("mem_port_arbiter: MAX_LS_STREAK and TIMEOUT_CYCLES must be >= 1");
  end

  state_t        state;
  logic [SW-1:0] streak;
  logic          ls_win;
  logic          tmo;

  // LS wins unless fetch has been waiting through a full streak of LS grants.
  assign ls_win = ls_req && !(if_req && (streak == STREAK_MAX));

`ifdef MEM_ARB_TIMEOUT_EN
  mem_arb_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_watchdog (
    .clk    (clk),
    .rst    (reset),
    .clear  (state == IDLE),
    .expire (tmo)
  );
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      streak    <= '0;
      if_gnt    <= 1'b0;
      if_rvalid <= 1'b0;
      if_rdata  <= '0;
      if_err    <= 1'b0;
      ls_gnt    <= 1'b0;
      ls_rvalid <= 1'b0;
      ls_rdata  <= '0;
      ls_err    <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
    end else begin
      if_gnt    <= 1'b0;
      ls_gnt    <= 1'b0;
      if_rvalid <= 1'b0;
      ls_rvalid <= 1'b0;
      if_err    <= 1'b0;
      ls_err    <= 1'b0;
      case (state)
        IDLE: begin
          if (ls_win) begin
            mem_addr  <= ls_addr;
            mem_wdata <= ls_wdata;
            mem_be    <= ls_be;
            mem_write <= ls_we;
            mem_read  <= !ls_we;
            ls_gnt    <= 1'b1;
            state     <= BUSY_LS;
            if (!if_req) begin
              streak <= '0;
            end else if (streak != STREAK_MAX) begin
              streak <= streak + 1'b1;
            end
          end else if (if_req) begin
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            mem_be    <= {BE_W{1'b1}};
            mem_write <= 1'b0;
            mem_read  <= 1'b1;
            if_gnt    <= 1'b1;
            streak    <= '0;
            state     <= BUSY_IF;
          end
        end
        BUSY_IF: begin
          if (mem_ready || tmo) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            if_rvalid <= 1'b1;
            if_rdata  <= mem_ready ? mem_rdata : '0;
            if_err    <= !mem_ready;
            state     <= IDLE;
          end
        end
        BUSY_LS: begin
          if (mem_ready || tmo) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            ls_rvalid <= 1'b1;
            ls_rdata  <= (mem_ready && !mem_write) ? mem_rdata : '0;
            ls_err    <= !mem_ready;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (MAX_LS_STREAK=4, TIMEOUT_CYCLES=8).
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt, if_rvalid, if_err;
  logic [31:0] if_rdata;
  logic        ls_req, ls_we;
  logic [31:0] ls_addr, ls_wdata;
  logic [3:0]  ls_be;
  logic        ls_gnt, ls_rvalid, ls_err;
  logic [31:0] ls_rdata;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int total = 0;
  int bad   = 0;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MAX_LS_STREAK(4), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_err(if_err),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_be(ls_be), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .ls_err(ls_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [9:0] flags();
    return {if_gnt, if_rvalid, if_err, ls_gnt, ls_rvalid, ls_err, mem_read, mem_write,
            mem_read & mem_write, 1'b0};
  endfunction

  initial begin
    #200000;
    $display("FAIL global_timeout observed=stuck expected=finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic exp_ls;
    reset = 1'b1; if_req = 0; if_addr = 0; ls_req = 0; ls_we = 0; ls_addr = 0;
    ls_wdata = 0; ls_be = 0; mem_ready = 0; mem_rdata = 0;
    tick(); tick();
    chk("rst_flags", {54'd0, flags()}, 64'd0);
    chk("rst_addr", {32'd0, mem_addr}, 64'd0);
    chk("rst_wdata", {32'd0, mem_wdata}, 64'd0);
    chk("rst_be", {60'd0, mem_be}, 64'd0);
    chk("rst_rdata", {if_rdata, ls_rdata}, 64'd0);
    reset = 1'b0;

    // Fetch only
    if_req = 1; if_addr = 32'h100;
    tick();
    chk("if_gnt", {63'd0, if_gnt}, 64'd1);
    chk("if_ls_gnt", {63'd0, ls_gnt}, 64'd0);
    chk("if_rd", {62'd0, mem_read, mem_write}, 64'd2);
    chk("if_addr", {32'd0, mem_addr}, 64'h100);
    if_req = 0; mem_ready = 1; mem_rdata = 32'h00A00093;
    tick();
    chk("if_rvalid", {62'd0, if_rvalid, if_gnt}, 64'd2);
    chk("if_rdata", {32'd0, if_rdata}, 64'h00A00093);
    chk("if_done_strobes", {61'd0, mem_read, mem_write, if_err}, 64'd0);
    mem_ready = 0; mem_rdata = 32'h0;
    tick();
    chk("if_rvalid_pulse", {63'd0, if_rvalid}, 64'd0);
    chk("if_rdata_hold", {32'd0, if_rdata}, 64'h00A00093);

    // Store with delayed ready; payload changed after grant must not leak
    ls_req = 1; ls_we = 1; ls_addr = 32'h2000; ls_wdata = 32'hCAFEF00D; ls_be = 4'b1111;
    tick();
    chk("st_gnt", {62'd0, ls_gnt, if_gnt}, 64'd2);
    ls_req = 0; ls_addr = 32'hDEAD0000; ls_wdata = 32'h0; ls_be = 4'b0;
    for (int i = 0; i < 4; i++) begin
      chk("st_strobes", {62'd0, mem_read, mem_write}, 64'd1);
      chk("st_addr", {32'd0, mem_addr}, 64'h2000);
      chk("st_wdata", {32'd0, mem_wdata}, 64'hCAFEF00D);
      chk("st_be", {60'd0, mem_be}, 64'hF);
      chk("st_no_rvalid", {63'd0, ls_rvalid}, 64'd0);
      if (i < 3) tick();
    end
    mem_ready = 1; mem_rdata = 32'h12345678;
    tick();
    chk("st_rvalid", {63'd0, ls_rvalid}, 64'd1);
    chk("st_rdata_zero", {32'd0, ls_rdata}, 64'd0);
    chk("st_done_strobes", {61'd0, mem_read, mem_write, ls_err}, 64'd0);
    mem_ready = 0;
    tick();
    chk("st_rvalid_pulse", {63'd0, ls_rvalid}, 64'd0);

    // Load
    ls_req = 1; ls_we = 0; ls_addr = 32'h3000; ls_be = 4'b0011;
    tick();
    chk("ld_strobes", {61'd0, ls_gnt, mem_read, mem_write}, 64'd6);
    chk("ld_be", {60'd0, mem_be}, 64'h3);
    ls_req = 0; mem_ready = 1; mem_rdata = 32'h000055AA;
    tick();
    chk("ld_rvalid", {62'd0, ls_rvalid, if_rvalid}, 64'd2);
    chk("ld_rdata", {32'd0, ls_rdata}, 64'h55AA);
    chk("ld_if_rdata_hold", {32'd0, if_rdata}, 64'h00A00093);

    // Contention with ready always high
    if_req = 1; ls_req = 1; ls_we = 0; mem_rdata = 32'h0000BEEF;
    tick();
    for (int g = 0; g < 10; g++) begin
      exp_ls = (g != 4 && g != 9);
      chk($sformatf("cont_gnt%0d", g), {62'd0, ls_gnt, if_gnt}, {62'd0, exp_ls, !exp_ls});
      chk("cont_excl", {63'd0, mem_read & mem_write}, 64'd0);
      tick();
      chk($sformatf("cont_rv%0d", g), {62'd0, ls_rvalid, if_rvalid}, {62'd0, exp_ls, !exp_ls});
      if (g == 9) begin
        if_req = 0; ls_req = 0;
      end
      tick();
    end
    mem_ready = 0;

    // Long wait: timeout abort, or indefinite wait without the feature
    ls_req = 1; ls_we = 0; ls_addr = 32'h4000; ls_be = 4'hF;
    tick();
    chk("to_gnt", {63'd0, ls_gnt}, 64'd1);
    ls_req = 0;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("to_wait", {62'd0, ls_rvalid, mem_read}, 64'd1);
    end
    tick();
`ifdef MEM_ARB_TIMEOUT_EN
    chk("to_abort", {60'd0, ls_rvalid, ls_err, mem_read, mem_write}, 64'hC);
    chk("to_rdata", {32'd0, ls_rdata}, 64'd0);
    tick();
    chk("to_err_pulse", {62'd0, ls_rvalid, ls_err}, 64'd0);
    ls_req = 1;
    tick();
    ls_req = 0;
    for (int i = 0; i < 7; i++) tick();
    mem_ready = 1; mem_rdata = 32'h77;
    tick();
    chk("to_race", {62'd0, ls_rvalid, ls_err}, 64'd2);
    chk("to_race_rdata", {32'd0, ls_rdata}, 64'h77);
    mem_ready = 0;
`else
    chk("nto_still_busy", {61'd0, ls_rvalid, ls_err, mem_read}, 64'd1);
    mem_ready = 1; mem_rdata = 32'h77;
    tick();
    chk("nto_done", {62'd0, ls_rvalid, ls_err}, 64'd2);
    chk("nto_rdata", {32'd0, ls_rdata}, 64'h77);
    mem_ready = 0;
`endif
    tick();

    // Reset mid-store, request held afterward
    ls_req = 1; ls_we = 1; ls_addr = 32'h5000; ls_wdata = 32'h11112222; ls_be = 4'hF;
    tick();
    chk("mr_busy", {62'd0, ls_gnt, mem_write}, 64'd3);
    #2 reset = 1'b1; mem_ready = 1;
    #1;
    chk("mr_flags", {54'd0, flags()}, 64'd0);
    chk("mr_addr", {32'd0, mem_addr}, 64'd0);
    tick();
    chk("mr_no_rvalid", {62'd0, ls_rvalid, mem_write}, 64'd0);
    reset = 1'b0; mem_ready = 0;
    tick();
    chk("mr_regrant", {62'd0, ls_gnt, mem_write}, 64'd3);
    chk("mr_regrant_addr", {32'd0, mem_addr}, 64'h5000);
    ls_req = 0; mem_ready = 1;
    tick();
    chk("mr_rvalid", {63'd0, ls_rvalid}, 64'd1);
    mem_ready = 0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the core's single memory port between the instruction-fetch requester (IF) and the load/store requester (LS, driven by the ALU read/write/addr/data outputs).
- Sequences one memory transaction at a time with req/gnt/rvalid handshakes.
- LS has priority; a streak counter prevents fetch starvation.
- Sits between the RISC_V core top and the memory.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MAX_LS_STREAK, 4, max consecutive LS grants while IF is waiting (≥1)
- TIMEOUT_CYCLES, 255, BUSY cycles before abort (used only with the optional feature)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  one-cycle grant to IF
- if_rvalid  out  1  one-cycle fetch-data-valid pulse
- if_rdata  out  DATA_W  fetch data
- if_err  out  1  fetch aborted, qualified by if_rvalid
- ls_req  in  1  load/store request
- ls_we  in  1  1=store, 0=load
- ls_addr  in  ADDR_W  load/store address
- ls_wdata  in  DATA_W  store data
- ls_be  in  4  byte enables
- ls_gnt  out  1  one-cycle grant to LS
- ls_rvalid  out  1  one-cycle completion pulse (load data or store ack)
- ls_rdata  out  DATA_W  load data
- ls_err  out  1  LS aborted, qualified by ls_rvalid
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_be  out  4  memory byte enables
- mem_ready  in  1  memory completes the current access this cycle
- mem_rdata  in  DATA_W  memory read data, valid with mem_ready

Behaviour:
- Reset: every output is 0, FSM goes to IDLE, streak counter is 0.
- Reset mid-transaction drops the transaction with no rvalid; the requester reissues it.
- All outputs are registered.
- FSM states: IDLE, BUSY_IF, BUSY_LS.
- IDLE, at a clock edge:
  - If a request is pending, select the winner.
  - Latch the winner's addr, wdata, be and we into the mem_* registers.
  - Assert mem_read (IF, or LS with ls_we=0) or mem_write (LS with ls_we=1).
  - Pulse the winner's gnt for exactly one cycle.
  - Move to BUSY_IF or BUSY_LS.
- Arbitration:
  - Only LS requesting: LS wins.
  - Only IF requesting: IF wins.
  - Both requesting: LS wins unless streak == MAX_LS_STREAK, in which case IF wins.
- Streak counter:
  - Increments on an LS grant while if_req=1.
  - Clears on an IF grant, or on an LS grant with if_req=0.
  - Saturates at MAX_LS_STREAK.
- BUSY_x:
  - mem_* outputs are held stable and requests are ignored.
  - On the edge where mem_ready=1: clear mem_read/mem_write, register mem_rdata into x_rdata (0 for stores), pulse x_rvalid for one cycle, return to IDLE.
- Latency:
  - req seen at edge 0 → gnt and strobe high in cycle 1.
  - mem_ready in cycle 1 → rvalid in cycle 2.
  - Minimum 2 cycles per access; at least one IDLE cycle between back-to-back accesses.
- Requesters hold req and payload until they see gnt. req still high in the cycle after gnt counts as a new request.
- x_rdata holds its last value until the next rvalid for that requester.
- if_err and ls_err are 0 unless the optional feature is enabled.
- mem_write and mem_read are never high together.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- Defined:
  - A BUSY-cycle counter starts at grant.
  - If it reaches TIMEOUT_CYCLES without mem_ready, clear the strobes, pulse x_rvalid with x_err=1 and x_rdata=0, and return to IDLE.
  - mem_ready in the same cycle as the timeout wins (normal completion, err=0).
- Undefined: no counter; BUSY waits for mem_ready indefinitely; err ports are tied to 0.

Decomposition:
- Package mem_arb_pkg holds: the state enum (IDLE/BUSY_IF/BUSY_LS), the ADDR_W/DATA_W defaults, the BE width constant, and the default TIMEOUT_CYCLES.
- One sub-module, mem_arb_watchdog (counter plus expire flag), instantiated only under MEM_ARB_TIMEOUT_EN.
- Arbitration and streak logic stay inline.

Test Plan:
- Reset while BUSY_LS with mem_write=1 → next cycle all outputs 0, no ls_rvalid; ls_req held afterward is re-granted.
- IF only: if_req=1, if_addr=0x100, mem_ready=1 one cycle after grant → if_gnt in cycle 1, mem_read=1 with mem_addr=0x100, if_rvalid in cycle 2 with if_rdata equal to mem_rdata (e.g. 0x00A00093).
- Store: ls_req=1, ls_we=1, ls_addr=0x2000, ls_wdata=0xCAFEF00D, ls_be=4'b1111, mem_ready delayed 3 cycles → mem_* stable for 4 cycles, ls_rvalid once, ls_rdata=0.
- Contention: both requests held continuously with MAX_LS_STREAK=4 and mem_ready always 1 → grant order LS,LS,LS,LS,IF,LS,LS,LS,LS,IF…
- With MEM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8: mem_ready held 0 → ls_rvalid=1, ls_err=1, ls_rdata=0 after 8 BUSY cycles. A second case with mem_ready asserted at cycle 8 → err=0.
